// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants, FSM encoding and buffer entry type for the fetch unit
package fetch_unit_pkg;
  localparam logic [31:0] BUBBLE_INSTR     = 32'h0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
  localparam logic [31:0] PC_INC           = 32'd4;
  typedef enum logic [1:0] {ST_RESET, ST_FETCH, ST_FULL} fetch_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO (push/pop/clear, full/empty), rst_n sync active-low;
// ports: wdata_i/push_i in, rdata_o head out (combinational), clear_i empties it
import fetch_unit_pkg::*;
module fetch_fifo #(
  parameter int WIDTH = $bits(fetch_entry_t),
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == FULL_CNT;
  assign empty_o = cnt_q == '0;
  assign rdata_o = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign do_push = push_i && (!full_o || do_pop);
  always_ff @(posedge clk)
    if (!rst_n || clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_q + AW'(do_pop);
      wr_q  <= wr_q + AW'(do_push);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata_i;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with bounded outstanding requests, in-order PC tags,
// fetch buffer feeding IF/ID, and flush/redirect with discard of in-flight responses.
// Ports: clk, rst_n (sync active-low), stall, flush, redirect_pc; imem_req_* / imem_rsp_*
// to instruction memory; pc_if, instr_if, instr_valid to IF/ID.
// Optional macro FETCH_PERF_EN adds perf_starve_cnt and perf_flush_cnt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc_if,
  output logic [31:0] instr_if,
  output logic        instr_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_starve_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] CAP = CW'(BUF_DEPTH);
  fetch_state_e state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  // occ counts outstanding (including ones to be discarded) plus buffered entries
  logic [CW-1:0] out_q, out_d, occ_q, occ_d, drop_q, drop_d;
  logic accept, rsp, keep, discard, pop;
  logic data_full, data_empty, tag_full, tag_empty;
  logic [31:0] tag_pc;
  fetch_entry_t head;
  assign imem_req_valid = rst_n && !flush && occ_q < CAP && !data_full && !tag_full;
  assign imem_req_addr  = fetch_pc_q;
  assign accept  = imem_req_valid && imem_req_ready;
  assign rsp     = rst_n && imem_rsp_valid;
  assign keep    = rsp && drop_q == '0;
  assign discard = rsp && drop_q != '0;
  assign pop     = rst_n && !stall && !flush && !data_empty;
  assign instr_valid = rst_n && !data_empty;
  assign pc_if       = instr_valid ? head.pc : 32'h0;
  assign instr_if    = instr_valid ? head.instr : BUBBLE_INSTR;
  always_comb begin
    out_d      = out_q + CW'(accept) - CW'(rsp);
    drop_d     = flush ? out_d : drop_q - CW'(discard);
    occ_d      = flush ? out_d : occ_q + CW'(accept) - CW'(discard) - CW'(pop);
    fetch_pc_d = flush ? redirect_pc : accept ? fetch_pc_q + PC_INC : fetch_pc_q;
    state_d    = (flush || state_q == ST_RESET) ? ST_FETCH : occ_d >= CAP ? ST_FULL : ST_FETCH;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q    <= ST_RESET;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      occ_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      occ_q      <= occ_d;
      drop_q     <= drop_d;
    end
  // tags of discarded requests are dropped by the clear, so only kept responses pop
  fetch_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_tag (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flush),
    .push_i  (accept),
    .pop_i   (keep && !tag_empty),
    .wdata_i (fetch_pc_q),
    .rdata_o (tag_pc),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );
  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(BUF_DEPTH)) u_data (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flush),
    .push_i  (keep && !flush),
    .pop_i   (pop),
    .wdata_i ({tag_pc, imem_rsp_data}),
    .rdata_o (head),
    .full_o  (data_full),
    .empty_o (data_empty)
  );
`ifdef FETCH_PERF_EN
  logic [31:0] starve_q, flushc_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      starve_q <= '0;
      flushc_q <= '0;
    end else begin
      if (!stall && data_empty && starve_q != '1) starve_q <= starve_q + 32'd1;
      if (flush && flushc_q != '1) flushc_q <= flushc_q + 32'd1;
    end
  assign perf_starve_cnt = starve_q;
  assign perf_flush_cnt  = flushc_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: queue-based reference model with randomized and directed stimulus
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h100;
  localparam int DEPTH = 2;
  logic clk = 0, rst_n = 0, stall = 0, flush = 0, imem_req_ready = 0, imem_rsp_valid = 0;
  logic [31:0] redirect_pc = 0, imem_rsp_data = 0;
  logic imem_req_valid, instr_valid;
  logic [31:0] imem_req_addr, pc_if, instr_if;
  fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .pc_if(pc_if), .instr_if(instr_if), .instr_valid(instr_valid)
  );
  always #5 clk = ~clk;
  typedef struct packed { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct packed { logic [31:0] pc; int due; logic dropped; } fl_t;
  ent_t bufq[$];
  fl_t fly[$];
  logic [31:0] popped[$];
  logic [31:0] mpc = RPC;
  int cyc = 0, lat = 1, n_tests = 0, n_fail = 0;
  logic d_rst_n = 0, d_stall = 0, d_flush = 0, d_ready = 1;
  logic [31:0] d_redir = 0;
  logic s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step();
    logic r, p, er, ev;
    logic [31:0] epc, ein;
    fl_t f;
    @(negedge clk);
    rst_n = d_rst_n; stall = d_stall; flush = d_flush; redirect_pc = d_redir; imem_req_ready = d_ready;
    r = rst_n && fly.size() > 0 && fly[0].due <= cyc;
    imem_rsp_valid = r;
    imem_rsp_data = r ? mem_data(fly[0].pc) : 32'h0;
    #1;
    er  = rst_n && !flush && (fly.size() + bufq.size() < DEPTH);
    ev  = rst_n && bufq.size() > 0;
    epc = ev ? bufq[0].pc : 32'h0;
    ein = ev ? bufq[0].data : 32'h0;
    chk("req_valid", 32'(imem_req_valid), 32'(er));
    if (er) chk("req_addr", imem_req_addr, mpc);
    chk("instr_valid", 32'(instr_valid), 32'(ev));
    chk("pc_if", pc_if, epc);
    chk("instr_if", instr_if, ein);
    if (dut.u_data.push_i) chk("no_overflow", 32'(dut.u_data.full_o && !dut.u_data.pop_i), 0);
    s_req = imem_req_valid; s_valid = instr_valid; s_addr = imem_req_addr; s_pc = pc_if; s_instr = instr_if;
    if (instr_valid && !stall && !flush) popped.push_back(pc_if);
    @(posedge clk);
    if (!rst_n) begin
      bufq.delete(); fly.delete(); mpc = RPC;
    end else begin
      p = !stall && !flush && bufq.size() > 0;
      if (p) void'(bufq.pop_front());
      if (r) begin
        f = fly.pop_front();
        if (!f.dropped && !flush) bufq.push_back('{f.pc, mem_data(f.pc)});
      end
      if (flush) begin
        bufq.delete();
        foreach (fly[i]) fly[i].dropped = 1'b1;
        mpc = redirect_pc;
      end else if (er && imem_req_ready) begin
        fly.push_back('{mpc, cyc + lat, 1'b0});
        mpc = mpc + 32'd4;
      end
    end
    cyc++;
  endtask
  task automatic wait_valid(input int budget);
    int n = 0;
    do begin step(); n++; end while (!s_valid && n < budget);
    chk("wait_valid", 32'(s_valid), 1);
  endtask
  task automatic wait_req(input int budget);
    int n = 0;
    do begin step(); n++; end while (!s_req && n < budget);
    chk("wait_req", 32'(s_req), 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] a0;
    d_rst_n = 0; d_stall = 0; d_flush = 0; d_ready = 1; lat = 1;
    step(); step();
    chk("rst_req", 32'(s_req), 0);
    chk("rst_valid", 32'(s_valid), 0);
    chk("rst_pc", s_pc, 0);
    chk("rst_instr", s_instr, 0);
    d_rst_n = 1; popped.delete();
    step();
    chk("first_req", 32'(s_req), 1);
    chk("first_addr", s_addr, 32'h100);
    step();
    step();
    chk("c3_valid", 32'(s_valid), 1);
    chk("c3_pc", s_pc, 32'h100);
    chk("c3_instr", s_instr, 32'hC0DE_0103);
    d_stall = 1; repeat (3) step();
    chk("stall_pc", s_pc, 32'h104);
    chk("stall_req", 32'(s_req), 0);
    d_stall = 0; repeat (3) step();
    chk("pop_n", 32'(popped.size() >= 3), 1);
    if (popped.size() >= 3) begin
      chk("pop0", popped[0], 32'h100);
      chk("pop1", popped[1], 32'h104);
      chk("pop2", popped[2], 32'h108);
    end
    d_rst_n = 0; step();
    d_rst_n = 1; lat = 3; d_stall = 1;
    step(); step();
    chk("fl_pre_req", 32'(s_req), 1);
    d_flush = 1; d_redir = 32'h200; step();
    chk("fl_no_req", 32'(s_req), 0);
    d_flush = 0; d_stall = 0;
    step();
    chk("redir_addr", s_addr, 32'h200);
    wait_valid(20);
    chk("redir_pc", s_pc, 32'h200);
    lat = 1; repeat (4) step();
    d_ready = 0; step(); a0 = s_addr;
    repeat (4) begin step(); chk("hold_addr", s_addr, a0); end
    chk("drain_valid", 32'(s_valid), 0);
    chk("drain_instr", s_instr, 0);
    d_ready = 1; d_flush = 1; d_redir = 32'hFFFF_FFFC; step();
    d_flush = 0;
    wait_req(10);
    chk("wrap_hi", s_addr, 32'hFFFF_FFFC);
    wait_req(10);
    chk("wrap_lo", s_addr, 32'h0);
    d_stall = 1; repeat (6) step();
    chk("full_valid", 32'(s_valid), 1);
    d_rst_n = 0; step();
    chk("mid_rst_valid", 32'(s_valid), 0);
    chk("mid_rst_req", 32'(s_req), 0);
    d_rst_n = 1; d_stall = 0; step();
    chk("restart_req", 32'(s_req), 1);
    chk("restart_addr", s_addr, RPC);
    repeat (3000) begin
      d_rst_n = $urandom_range(0, 199) != 0;
      d_stall = $urandom_range(0, 9) < 3;
      d_flush = $urandom_range(0, 19) == 0;
      d_redir = $urandom() & 32'hFFFF_FFFC;
      d_ready = $urandom_range(0, 9) < 7;
      lat = $urandom_range(1, 4);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
